// File: rtl/safety_island_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : safety_island_boot_ctrl_if
// Brief    : Register request/response bundle for the safety-island boot ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface safety_island_boot_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [4:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;

  modport slave (
    input  req_valid_i,
    input  req_we_i,
    input  req_addr_i,
    input  req_wdata_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_rdata_o,
    output rsp_error_o
  );

  modport master (
    output req_valid_i,
    output req_we_i,
    output req_addr_i,
    output req_wdata_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_rdata_o,
    input  rsp_error_o
  );
endinterface
`default_nettype wire

// File: rtl/safety_island_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : safety_island_boot_ctrl
// Brief    : Boot CSRs, core reset/fetch sequencing and EOC capture
// Revision : 1.0 - initial release
// ============================================================================
module safety_island_boot_ctrl #(
  parameter logic [31:0] ROM_BOOT_ADDR = 32'h1A00_0000,
  parameter int unsigned RST_DLY       = 8,
  parameter logic [1:0]  BOOTMODE_RST  = 2'd0
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_ni,
  safety_island_boot_ctrl_if.slave    bus,
  output logic                        core_rst_no,
  output logic                        fetch_en_o,
  output logic [31:0]                 boot_addr_o,
  output logic                        eoc_o,
  output logic [30:0]                 exit_status_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RELEASE = 3'd1,
    S_FETCH   = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [4:0] c_ADDR_BOOTMODE  = 5'h00;
  localparam logic [4:0] c_ADDR_BOOT_ADDR = 5'h04;
  localparam logic [4:0] c_ADDR_FETCH_EN  = 5'h08;
  localparam logic [4:0] c_ADDR_EOC       = 5'h0C;
  localparam logic [4:0] c_ADDR_STATE     = 5'h10;
  localparam logic [7:0] c_CNT_LAST       = 8'(RST_DLY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [1:0]  r_bootmode;
  logic [31:0] r_boot_addr_csr;
  logic [31:0] r_boot_addr_out;
  logic        r_eoc;
  logic [30:0] r_exit;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;

  logic        w_sel_bootmode;
  logic        w_sel_boot_addr;
  logic        w_sel_fetch_en;
  logic        w_sel_eoc;
  logic        w_sel_state;
  logic        w_addr_err;
  logic        w_pre_run;
  logic        w_err;
  logic        w_wr_ok;
  logic        w_fetch_req;
  logic        w_eoc_wr;
  logic [31:0] w_rdata;

  // ---------------------------------------------------------------------------
  // Request decode, evaluated against the current (pre-transition) state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_bootmode  = (bus.req_addr_i == c_ADDR_BOOTMODE);
    w_sel_boot_addr = (bus.req_addr_i == c_ADDR_BOOT_ADDR);
    w_sel_fetch_en  = (bus.req_addr_i == c_ADDR_FETCH_EN);
    w_sel_eoc       = (bus.req_addr_i == c_ADDR_EOC);
    w_sel_state     = (bus.req_addr_i == c_ADDR_STATE);
    w_addr_err      = (bus.req_addr_i[1:0] != 2'b00) || (bus.req_addr_i > c_ADDR_STATE);
    w_pre_run       = (r_state == S_IDLE) || (r_state == S_RELEASE) || (r_state == S_FETCH);

    w_err = 1'b0;
    if (bus.req_valid_i) begin
      if (w_addr_err) begin
        w_err = 1'b1;
      end else if (bus.req_we_i) begin
        w_err = w_sel_state
             || ((w_sel_bootmode || w_sel_boot_addr) && (r_state != S_IDLE))
             || (w_sel_fetch_en && r_bootmode[1])
             || (w_sel_eoc && w_pre_run);
      end
    end

    w_wr_ok     = bus.req_valid_i && bus.req_we_i && !w_err;
    w_fetch_req = w_wr_ok && w_sel_fetch_en && bus.req_wdata_i[0] && (r_bootmode == 2'd1);
    w_eoc_wr    = w_wr_ok && w_sel_eoc && (r_state == S_RUN);
  end

  always_comb begin
    w_rdata = 32'h0;
    if (bus.req_valid_i && !bus.req_we_i && !w_err) begin
      if (w_sel_bootmode) begin
        w_rdata = {30'h0, r_bootmode};
      end else if (w_sel_boot_addr) begin
        w_rdata = r_boot_addr_csr;
      end else if (w_sel_eoc) begin
        w_rdata = {r_eoc, r_exit};
      end else if (w_sel_state) begin
        w_rdata = {29'h0, r_state};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Boot sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    core_rst_no = 1'b0;
    fetch_en_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_bootmode == 2'd0) || w_fetch_req) begin
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        core_rst_no = 1'b1;
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        core_rst_no = 1'b1;
        fetch_en_o  = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        core_rst_no = 1'b1;
        fetch_en_o  = 1'b1;
        if (w_eoc_wr && bus.req_wdata_i[31]) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        core_rst_no = 1'b1;
        fetch_en_o  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counter starts from zero on the first RELEASE cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni || (r_state != S_RELEASE)) begin
      r_cnt <= 8'h0;
    end else begin
      r_cnt <= r_cnt + 8'h1;
    end
  end

  // ---------------------------------------------------------------------------
  // CSR storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_bootmode      <= BOOTMODE_RST;
      r_boot_addr_csr <= 32'h0;
    end else begin
      if (w_wr_ok && w_sel_bootmode) begin
        r_bootmode <= bus.req_wdata_i[1:0];
      end
      if (w_wr_ok && w_sel_boot_addr) begin
        r_boot_addr_csr <= bus.req_wdata_i;
      end
    end
  end

  // Boot address tracks the CSRs only while the core is held in reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_boot_addr_out <= 32'h0;
    end else if (r_state == S_IDLE) begin
      r_boot_addr_out <= (r_bootmode == 2'd0) ? ROM_BOOT_ADDR : r_boot_addr_csr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_eoc  <= 1'b0;
      r_exit <= 31'h0;
    end else if (w_eoc_wr) begin
      r_exit <= bus.req_wdata_i[30:0];
      if (bus.req_wdata_i[31]) begin
        r_eoc <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response channel
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= bus.req_valid_i;
      r_rsp_rdata <= w_rdata;
      r_rsp_error <= w_err;
    end
  end

  assign bus.req_ready_o = 1'b1;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_error_o = r_rsp_error;

  assign boot_addr_o   = r_boot_addr_out;
  assign eoc_o         = r_eoc;
  assign exit_status_o = r_exit;

endmodule
`default_nettype wire
